// File: rtl/chacha_pkg.sv
// Shared constants and FSM state type for the ChaCha20 output path.
// Defaults describe a 512-bit block streamed as 32-bit words.
package chacha_pkg;

    localparam int QUARTER_W = 128;
    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 4 * QUARTER_W;
    localparam int WORDS     = BLOCK_W / WORD_W;
    localparam int IDX_W     = $clog2(WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on the rising edge of a level input.
// prev resets low, so a level already high after reset counts as an edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/cipher_block_serializer.sv
// Captures a ciphertext block on encryptor ready and streams it out
// most-significant word first over a valid/ready handshake.
module cipher_block_serializer
    import chacha_pkg::*;
#(
    parameter int N = QUARTER_W,
    parameter int W = WORD_W
) (
    input  logic                          clk_20_Hz,
    input  logic                          rst,
    input  logic [4*N-1:0]                block_in,
    input  logic                          block_ready,
    output logic [W-1:0]                  word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          word_last,
    output logic [$clog2(4*N/W)-1:0]      word_index,
    output logic                          busy,
    output logic                          overrun,
    output logic [15:0]                   blocks_sent
);

    localparam int BLK = 4 * N;
    localparam int NW  = BLK / W;
    localparam int IW  = $clog2(NW);

    state_t          state;
    state_t          state_nx;
    logic [BLK-1:0]  sreg;
    logic [IW-1:0]   idx;
    logic [15:0]     sent_cnt;
    logic            ovr;
    logic            rise;
    logic            xfer;
    logic            last_xfer;
    logic            load;
    logic            drop;

    rise_detect u_rise (
        .clk   (clk_20_Hz),
        .rst   (rst),
        .level (block_ready),
        .pulse (rise)
    );

    always_comb begin
        xfer      = (state == SEND) & word_ready;
        last_xfer = xfer & (idx == IW'(NW - 1));
        state_nx  = state;
        load      = 1'b0;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = SEND;
                    load     = 1'b1;
                end
            end
            SEND: begin
                // A block landing on the final transfer chains back-to-back.
                if (last_xfer) begin
                    if (rise) load     = 1'b1;
                    else      state_nx = IDLE;
                end else if (rise) begin
                    drop = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_20_Hz or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sreg     <= '0;
            idx      <= '0;
            sent_cnt <= '0;
            ovr      <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                sreg <= block_in;
                idx  <= '0;
            end else if (xfer) begin
                sreg <= sreg << W;
                idx  <= idx + IW'(1);
            end
            if (last_xfer) sent_cnt <= sent_cnt + 16'd1;
            if (drop)      ovr      <= 1'b1;
        end
    end

    assign busy        = (state == SEND);
    assign word_valid  = busy;
    assign word_out    = busy ? sreg[BLK-1 -: W] : '0;
    assign word_last   = busy & (idx == IW'(NW - 1));
    assign word_index  = idx;
    assign overrun     = ovr;
    assign blocks_sent = sent_cnt;

endmodule

// File: tb/tb_cipher_block_serializer.sv
// Directed and randomized checks of the block serializer against
// word-order arithmetic on the captured block.
module tb_cipher_block_serializer;

    logic         clk_20_Hz;
    logic         rst;
    logic [511:0] block_in;
    logic         block_ready;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic [3:0]   word_index;
    logic         busy;
    logic         overrun;
    logic [15:0]  blocks_sent;

    int n_tests = 0;
    int n_fail  = 0;

    cipher_block_serializer dut (
        .clk_20_Hz   (clk_20_Hz),
        .rst         (rst),
        .block_in    (block_in),
        .block_ready (block_ready),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_last   (word_last),
        .word_index  (word_index),
        .busy        (busy),
        .overrun     (overrun),
        .blocks_sent (blocks_sent)
    );

    initial begin
        clk_20_Hz = 1'b0;
        forever #5 clk_20_Hz = ~clk_20_Hz;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ew(input logic [511:0] b, input int k);
        logic [511:0] t;
        t = b >> (32 * (15 - k));
        return t[31:0];
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk_word(input logic [511:0] blk, input int k);
        chk($sformatf("w%0d_valid", k), 32'(word_valid), 32'd1);
        chk($sformatf("w%0d_data", k), word_out, ew(blk, k));
        chk($sformatf("w%0d_index", k), 32'(word_index), 32'(k));
        chk($sformatf("w%0d_last", k), 32'(word_last), 32'(k == 15));
    endtask

    task automatic start(input logic [511:0] blk);
        block_ready = 1'b0;
        @(negedge clk_20_Hz);
        block_in    = blk;
        block_ready = 1'b1;
        @(negedge clk_20_Hz);
        block_ready = 1'b0;
    endtask

    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready
    task automatic drain(input logic [511:0] blk, input int mode,
                         input int stop_k, input int pulse_at,
                         input logic [511:0] alt);
        int  k   = 0;
        int  cyc = 0;
        int  ph  = 0;
        logic r;
        while (k < stop_k) begin
            if (cyc >= 200) begin
                chk("drain_budget", 32'(k), 32'(stop_k));
                break;
            end
            chk_word(blk, k);
            if (pulse_at >= 0) begin
                if (ph == 0 && k == pulse_at) begin
                    block_ready = 1'b0;
                    ph = 1;
                end else if (ph == 1) begin
                    block_in    = alt;
                    block_ready = 1'b1;
                    ph = 2;
                end
            end
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = (cyc % 3 == 0);
            else                r = 1'($urandom % 2);
            word_ready = r;
            if (r) k++;
            cyc++;
            @(negedge clk_20_Hz);
        end
        word_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] sent);
        chk({tag, "_valid"}, 32'(word_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_last"}, 32'(word_last), 32'd0);
        chk({tag, "_sent"}, 32'(blocks_sent), 32'(sent));
    endtask

    logic [511:0] a;
    logic [511:0] b;
    logic [511:0] c;

    initial begin
        for (int i = 0; i < 64; i++) a[511 - 8*i -: 8] = 8'(i);
        rst         = 1'b0;
        block_in    = '0;
        block_ready = 1'b0;
        word_ready  = 1'b0;
        #1;
        chk("rst_word", word_out, 32'd0);
        chk("rst_index", 32'(word_index), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk_idle("rst", 16'd0);
        @(negedge clk_20_Hz);
        rst = 1'b1;
        @(negedge clk_20_Hz);

        // full-rate stream of the byte-ramp block
        start(a);
        drain(a, 0, 16, -1, '0);
        chk_idle("ramp", 16'd1);

        // stalled stream: words hold while ready is low
        start(a);
        drain(a, 1, 16, -1, '0);
        chk_idle("stall", 16'd2);

        // second rising edge mid-block is dropped
        b = rand_block();
        start(b);
        drain(b, 0, 16, 5, rand_block());
        chk("ovr_set", 32'(overrun), 32'd1);
        chk_idle("ovr", 16'd3);
        b = rand_block();
        start(b);
        drain(b, 2, 16, -1, '0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk_idle("ovr2", 16'd4);

        // asynchronous reset at word 7
        start(a);
        drain(a, 2, 7, -1, '0);
        rst = 1'b0;
        #1;
        chk("mid_rst_word", word_out, 32'd0);
        chk("mid_rst_index", 32'(word_index), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk_idle("mid_rst", 16'd0);
        block_ready = 1'b1;
        block_in    = a;
        @(negedge clk_20_Hz);
        rst = 1'b1;
        @(negedge clk_20_Hz);
        block_ready = 1'b0;
        drain(a, 2, 16, -1, '0);
        chk_idle("resend", 16'd1);

        // rising edge coincident with the final transfer
        b = rand_block();
        c = rand_block();
        start(b);
        drain(b, 0, 15, -1, '0);
        chk_word(b, 15);
        block_in    = c;
        block_ready = 1'b1;
        word_ready  = 1'b1;
        @(negedge clk_20_Hz);
        word_ready  = 1'b0;
        chk("b2b_sent", 32'(blocks_sent), 32'd2);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        block_ready = 1'b0;
        drain(c, 2, 16, -1, '0);
        chk_idle("b2b_end", 16'd3);

        // blocks_sent wraps
        force dut.sent_cnt = 16'hFFFF;
        #1;
        release dut.sent_cnt;
        @(negedge clk_20_Hz);
        chk("wrap_pre", 32'(blocks_sent), 32'h0000_FFFF);
        b = rand_block();
        start(b);
        drain(b, 2, 16, -1, '0);
        chk_idle("wrap", 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
